// File: rtl/player_action_sequencer.sv
// -----------------------------------------------------------------------------
// player_action_sequencer
//
// Per-player action controller sitting between the debounced input block and
// the sprite renderer. Buttons and opponent-hit events are latched between
// video frames and resolved into one state transition per frame_tick.
// Everything the renderer and game logic see is registered and changes only on
// the clk edge where frame_tick is high.
//
// Ports
//   clk            system clock
//   rst_l          asynchronous active-low reset
//   frame_tick     single-clk pulse, once per video frame
//   btn_left       level, move left
//   btn_right      level, move right
//   btn_punch      level; a rising edge requests a punch
//   btn_block      level, hold to block
//   hit_in         single-clk pulse, opponent attack connected
//   action[6:0]    {state[2:0], frame[3:0]} for the sprite renderer
//   attack_active  high while in ACTIVE (hitbox live)
//   blocking       high while in BLOCK
//   busy           high in WINDUP/ACTIVE/RECOVER/STUN (buttons locked out)
//
// Parameters must lie in 1..31 (WALK_FRAMES in 1..16).
// -----------------------------------------------------------------------------
module player_action_sequencer #(
    parameter int unsigned FRAME_HOLD    = 6,
    parameter int unsigned WALK_FRAMES   = 4,
    parameter int unsigned WINDUP_TICKS  = 3,
    parameter int unsigned ACTIVE_TICKS  = 2,
    parameter int unsigned RECOVER_TICKS = 5,
    parameter int unsigned STUN_TICKS    = 12
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_punch,
    input  logic       btn_block,
    input  logic       hit_in,
    output logic [6:0] action,
    output logic       attack_active,
    output logic       blocking,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WALK    = 3'd1,
        ST_WINDUP  = 3'd2,
        ST_ACTIVE  = 3'd3,
        ST_RECOVER = 3'd4,
        ST_BLOCK   = 3'd5,
        ST_STUN    = 3'd6,
        ST_UNUSED  = 3'd7
    } state_e;

    localparam logic [4:0] HOLD_LAST    = 5'(FRAME_HOLD - 1);
    localparam logic [3:0] WALK_LAST    = 4'(WALK_FRAMES - 1);
    localparam logic [4:0] WINDUP_LAST  = 5'(WINDUP_TICKS - 1);
    localparam logic [4:0] ACTIVE_LAST  = 5'(ACTIVE_TICKS - 1);
    localparam logic [4:0] RECOVER_LAST = 5'(RECOVER_TICKS - 1);
    localparam logic [4:0] STUN_LAST    = 5'(STUN_TICKS - 1);

    state_e     state_q, state_d;
    logic [4:0] tick_q, tick_d;       // ticks spent in the current timed phase
    logic [4:0] hold_q, hold_d;       // ticks spent on the current walk frame
    logic [3:0] frame_q, frame_d;
    logic       punch_req_q, punch_req_d;
    logic       hit_pend_q, hit_pend_d;
    logic       punch_prev_q;
    logic       attack_q, attack_d;
    logic       blocking_q, blocking_d;
    logic       busy_q, busy_d;

    logic       punch_rise;
    logic       hit_now;
    logic       punch_now;
    logic [4:0] phase_last;
    state_e     phase_next;

    // Events arriving in the same clk as the tick count for that tick.
    assign punch_rise = btn_punch & ~punch_prev_q;
    assign hit_now    = hit_pend_q | hit_in;
    assign punch_now  = punch_req_q | punch_rise;

    // Length and successor of the timed phase currently occupied.
    always_comb begin
        phase_last = STUN_LAST;
        phase_next = ST_IDLE;
        unique case (state_q)
            ST_WINDUP:  begin phase_last = WINDUP_LAST;  phase_next = ST_ACTIVE;  end
            ST_ACTIVE:  begin phase_last = ACTIVE_LAST;  phase_next = ST_RECOVER; end
            ST_RECOVER: begin phase_last = RECOVER_LAST; phase_next = ST_IDLE;    end
            default:    begin phase_last = STUN_LAST;    phase_next = ST_IDLE;    end
        endcase
    end

    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        hold_d      = hold_q;
        frame_d     = frame_q;
        punch_req_d = punch_req_q | punch_rise;
        hit_pend_d  = hit_pend_q | hit_in;

        if (frame_tick) begin
            // Pending requests live for one frame only, consumed or not.
            punch_req_d = 1'b0;
            hit_pend_d  = 1'b0;

            if (hit_now && state_q != ST_BLOCK) begin
                state_d = ST_STUN;
                tick_d  = '0;
            end else begin
                unique case (state_q)
                    ST_WINDUP, ST_ACTIVE, ST_RECOVER, ST_STUN: begin
                        if (tick_q == phase_last) begin
                            state_d = phase_next;
                            tick_d  = '0;
                        end else begin
                            tick_d  = tick_q + 5'd1;
                        end
                    end
                    ST_IDLE, ST_WALK, ST_BLOCK: begin
                        tick_d = '0;
                        if (punch_now && !(state_q == ST_BLOCK && btn_block)) begin
                            state_d = ST_WINDUP;
                        end else if (btn_block) begin
                            state_d = ST_BLOCK;
                        end else if (btn_left ^ btn_right) begin
                            state_d = ST_WALK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        tick_d  = '0;
                    end
                endcase
            end

            // Frame field follows the state being entered.
            unique case (state_d)
                ST_WALK: begin
                    if (state_q != ST_WALK) begin
                        hold_d  = '0;
                        frame_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        frame_d = (frame_q == WALK_LAST) ? 4'd0 : frame_q + 4'd1;
                    end else begin
                        hold_d  = hold_q + 5'd1;
                    end
                end
                ST_WINDUP, ST_ACTIVE, ST_RECOVER, ST_STUN: begin
                    hold_d  = '0;
                    frame_d = (tick_d > 5'd15) ? 4'd15 : tick_d[3:0];
                end
                default: begin
                    hold_d  = '0;
                    frame_d = '0;
                end
            endcase
        end
    end

    // Flags are registered from the next state so they line up with action.
    always_comb begin
        attack_d   = (state_d == ST_ACTIVE);
        blocking_d = (state_d == ST_BLOCK);
        busy_d     = (state_d == ST_WINDUP) || (state_d == ST_ACTIVE) ||
                     (state_d == ST_RECOVER) || (state_d == ST_STUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            hold_q       <= '0;
            frame_q      <= '0;
            punch_req_q  <= 1'b0;
            hit_pend_q   <= 1'b0;
            punch_prev_q <= 1'b0;
            attack_q     <= 1'b0;
            blocking_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            hold_q       <= hold_d;
            frame_q      <= frame_d;
            punch_req_q  <= punch_req_d;
            hit_pend_q   <= hit_pend_d;
            punch_prev_q <= btn_punch;
            attack_q     <= attack_d;
            blocking_q   <= blocking_d;
            busy_q       <= busy_d;
        end
    end

    assign action        = {state_q, frame_q};
    assign attack_active = attack_q;
    assign blocking      = blocking_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_player_action_sequencer.sv
module tb_player_action_sequencer;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_punch = 1'b0;
    logic       btn_block = 1'b0;
    logic       hit_in = 1'b0;
    logic [6:0] action;
    logic       attack_active;
    logic       blocking;
    logic       busy;

    player_action_sequencer dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .frame_tick    (frame_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_punch     (btn_punch),
        .btn_block     (btn_block),
        .hit_in        (hit_in),
        .action        (action),
        .attack_active (attack_active),
        .blocking      (blocking),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observed outputs packed as {action, attack_active, blocking, busy}.
    function automatic logic [9:0] outs(input logic [6:0] a, input bit att, input bit blk, input bit bsy);
        return {a, att, blk, bsy};
    endfunction

    // ---------------- reference model (game rules, not hardware) -------------
    localparam int IDLE = 0, WALK = 1, WINDUP = 2, ACTIVE = 3, RECOVER = 4, BLOCK = 5, STUN = 6;
    localparam int HOLD = 6, NFRAMES = 4;

    int m_state = IDLE;
    int m_elapsed = 0;       // ticks since the current state was entered
    bit m_prev_punch = 0;
    bit m_hit_pend = 0;
    bit m_punch_pend = 0;

    function automatic int duration(input int s);
        case (s)
            WINDUP:  return 3;
            ACTIVE:  return 2;
            RECOVER: return 5;
            STUN:    return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int successor(input int s);
        case (s)
            WINDUP:  return ACTIVE;
            ACTIVE:  return RECOVER;
            default: return IDLE;
        endcase
    endfunction

    task automatic model_tick(input bit hit, input bit punch, input bit blk, input bit l, input bit r);
        if (hit && m_state != BLOCK) begin
            m_state = STUN; m_elapsed = 0;
        end else if (duration(m_state) > 0) begin
            if (m_elapsed + 1 >= duration(m_state)) begin
                m_state = successor(m_state); m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else if (punch && !(m_state == BLOCK && blk)) begin
            m_state = WINDUP; m_elapsed = 0;
        end else if (blk) begin
            m_state = BLOCK; m_elapsed = 0;
        end else if (l != r) begin
            if (m_state == WALK) m_elapsed++;
            else begin m_state = WALK; m_elapsed = 0; end
        end else begin
            m_state = IDLE; m_elapsed = 0;
        end
    endtask

    function automatic logic [9:0] model_out();
        int fr;
        logic [2:0] s3;
        if (m_state == WALK) fr = (m_elapsed / HOLD) % NFRAMES;
        else if (duration(m_state) > 0) fr = (m_elapsed > 15) ? 15 : m_elapsed;
        else fr = 0;
        s3 = 3'(m_state);
        return outs({s3, 4'(fr)}, m_state == ACTIVE, m_state == BLOCK,
                    duration(m_state) > 0);
    endfunction

    // ---------------- scoreboard ---------------------------------------------
    logic [9:0] exp_q[$];
    logic [9:0] last_exp = '0;

    // Pops on every tick edge; between ticks the outputs must hold.
    always @(posedge clk) begin
        logic [9:0] e;
        logic       was_tick;
        if (!rst_l) begin
            last_exp = '0;
        end else begin
            was_tick = frame_tick;
            e = last_exp;
            if (was_tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: tick with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                end
                last_exp = e;
            end
            #1;
            check(was_tick ? "tick_outputs" : "hold_outputs",
                  32'({action, attack_active, blocking, busy}), 32'(e));
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic step(input bit tick, input bit l, input bit r, input bit p, input bit b, input bit h);
        bit rise;
        @(negedge clk);
        frame_tick = tick;
        btn_left   = l;
        btn_right  = r;
        btn_punch  = p;
        btn_block  = b;
        hit_in     = h;
        rise = p && !m_prev_punch;
        m_prev_punch = p;
        if (tick) begin
            model_tick(m_hit_pend || h, m_punch_pend || rise, b, l, r);
            exp_q.push_back(model_out());
            m_hit_pend = 0;
            m_punch_pend = 0;
        end else begin
            m_hit_pend   = m_hit_pend || h;
            m_punch_pend = m_punch_pend || rise;
        end
    endtask

    task automatic ticks(input int n, input bit l, input bit r, input bit b);
        for (int i = 0; i < n; i++) step(1, l, r, 0, b, 0);
    endtask

    // Direct check of outputs right after the tick edge that follows a step.
    task automatic expect_now(input string name, input logic [9:0] exp);
        @(posedge clk);
        #2;
        check(name, 32'({action, attack_active, blocking, busy}), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0;
        frame_tick = 0; btn_left = 0; btn_right = 0; btn_punch = 0; btn_block = 0; hit_in = 0;
        #1;
        check("reset_action", 32'(action), 32'h0);
        check("reset_flags", 32'({attack_active, blocking, busy}), 32'h0);
        repeat (2) @(negedge clk);
        m_state = IDLE; m_elapsed = 0;
        m_prev_punch = 0; m_hit_pend = 0; m_punch_pend = 0;
        exp_q.delete();
        rst_l = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        bit l, r, b;

        do_reset();

        // T1: reset in the middle of ACTIVE
        step(0, 0, 0, 1, 0, 0);
        ticks(4, 0, 0, 0);
        expect_now("t1_in_active", outs(7'h30, 1, 0, 1));
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        expect_now("t1_idle_after_reset", outs(7'h00, 0, 0, 0));

        // T2: walk right for 30 ticks, then release
        ticks(7, 0, 1, 0);
        expect_now("t2_walk_frame1", outs(7'h11, 0, 0, 0));
        ticks(23, 0, 1, 0);
        expect_now("t2_walk_wrap", outs(7'h10, 0, 0, 0));
        step(1, 0, 0, 0, 0, 0);
        expect_now("t2_release_idle", outs(7'h00, 0, 0, 0));

        // T3: punch lasts exactly 10 ticks
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, 0, 0);
            @(posedge clk);
            #2;
            if (busy) busy_cnt++;
        end
        check("t3_busy_ticks", 32'(busy_cnt), 32'd10);

        // T4: hit during ACTIVE, second hit at STUN tick 8
        step(0, 0, 0, 1, 0, 0);
        ticks(4, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        expect_now("t4_stun_from_active", outs(7'h60, 0, 0, 1));
        ticks(8, 0, 0, 0);
        expect_now("t4_stun_tick8", outs(7'h68, 0, 0, 1));
        step(1, 0, 0, 0, 0, 1);
        expect_now("t4_stun_restart", outs(7'h60, 0, 0, 1));
        ticks(11, 0, 0, 0);
        expect_now("t4_stun_last", outs(7'h6B, 0, 0, 1));
        step(1, 0, 0, 0, 0, 0);
        expect_now("t4_stun_exit", outs(7'h00, 0, 0, 0));

        // T5: block absorbs hits and punches
        step(1, 0, 0, 0, 1, 0);
        expect_now("t5_block", outs(7'h50, 0, 1, 0));
        step(0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 0);
        expect_now("t5_hit_absorbed", outs(7'h50, 0, 1, 0));
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        expect_now("t5_punch_ignored", outs(7'h50, 0, 1, 0));
        step(1, 0, 0, 0, 0, 0);
        expect_now("t5_punch_dropped", outs(7'h00, 0, 0, 0));

        // T6: hit on the tick clk; punch rise and hit on the same tick
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0, 1);
        expect_now("t6_hit_same_clk", outs(7'h60, 0, 0, 1));
        ticks(12, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1);
        expect_now("t6_hit_beats_punch", outs(7'h60, 0, 0, 1));
        step(1, 0, 0, 0, 0, 0);
        ticks(11, 0, 0, 0);
        expect_now("t6_punch_not_kept", outs(7'h00, 0, 0, 0));

        // Randomised play with occasional resets
        l = 0; r = 0; b = 0;
        for (int f = 0; f < 1500; f++) begin
            int gap;
            if ($urandom_range(0, 3) == 0) l = 1'($urandom);
            if ($urandom_range(0, 3) == 0) r = 1'($urandom);
            if ($urandom_range(0, 5) == 0) b = 1'($urandom);
            gap = $urandom_range(0, 3);
            for (int c = 0; c < gap; c++)
                step(0, l, r, ($urandom_range(0, 3) == 0), b, ($urandom_range(0, 19) == 0));
            step(1, l, r, ($urandom_range(0, 3) == 0), b, ($urandom_range(0, 14) == 0));
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
